tt_scan_initiator: RTL and testbench

//   Sequential stimulus/capture engine for the combinational NAND-built function blocks.

---
 rtl/tt_scan_pkg.sv | 8 +
 rtl/tt_vec_counter.sv | 36 +++
 rtl/tt_scan_initiator.sv | 92 +++++++++
 tb/tb_tt_scan_initiator.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/tt_scan_pkg.sv
// tt_scan_pkg: shared state encoding and sizing helpers for the truth-table scan engine.
package tt_scan_pkg;
  typedef enum logic {IDLE, HOLD} state_t;
  localparam int SETTLE_W = 4;
  function automatic int nvec(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/tt_vec_counter.sv
// tt_vec_counter: steps the vector index, holding each one for SETTLE+1 cycles.
module tt_vec_counter import tt_scan_pkg::*; #(
  parameter int N_IN   = 3,
  parameter int SETTLE = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_run,
  output logic [N_IN-1:0] o_vec,
  output logic            o_sample_en,
  output logic            o_last_vec
);
  localparam logic [N_IN:0]         LAST_IDX = (N_IN+1)'(nvec(N_IN) - 1);
  localparam logic [SETTLE_W-1:0]   HOLD_END = SETTLE_W'(SETTLE);
  logic [N_IN:0]       r_idx;
  logic [SETTLE_W-1:0] r_cnt;
  assign o_vec       = r_idx[N_IN-1:0];
  assign o_sample_en = i_run && (r_cnt == HOLD_END);
  assign o_last_vec  = r_idx == LAST_IDX;
  // the index returns to 0 after the last sample rather than wrapping onto an unsampled value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_idx <= '0;
      r_cnt <= '0;
    end else if (o_sample_en) begin
      r_idx <= o_last_vec ? '0 : r_idx + (N_IN+1)'(1);
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + SETTLE_W'(1);
    end
  end
endmodule

// File: rtl/tt_scan_initiator.sv
// tt_scan_initiator: walks every input vector of a combinational block and captures its truth table.
// Optional TT_CHECK_EN adds exp_tt/mismatch/fail_idx comparison against an expected table.
module tt_scan_initiator import tt_scan_pkg::*; #(
  parameter int N_IN   = 3,
  parameter int N_OUT  = 2,
  parameter int SETTLE = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [N_IN-1:0]              vec,
  input  logic [N_OUT-1:0]             fout,
  output logic [N_OUT*nvec(N_IN)-1:0]  tt
`ifdef TT_CHECK_EN
  ,
  input  logic [N_OUT*nvec(N_IN)-1:0]  exp_tt,
  output logic                         mismatch,
  output logic [N_IN-1:0]              fail_idx
`endif
);
  localparam int NV = nvec(N_IN);
  localparam int TW = N_OUT * NV;
  state_t          r_state;
  logic            w_accept;
  logic            w_sample;
  logic            w_last;
  logic [TW-1:0]   w_tt_next;
  assign w_accept = (r_state == IDLE) && start;
  tt_vec_counter #(.N_IN(N_IN), .SETTLE(SETTLE)) u_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_clear     (w_accept),
    .i_run       (r_state == HOLD),
    .o_vec       (vec),
    .o_sample_en (w_sample),
    .o_last_vec  (w_last)
  );
  for (genvar k = 0; k < N_OUT; k++) begin : g_out
    for (genvar i = 0; i < NV; i++) begin : g_vec
      assign w_tt_next[k*NV+i] = (vec == N_IN'(i)) ? fout[k] : tt[k*NV+i];
    end
  end
`ifdef TT_CHECK_EN
  logic [TW-1:0] r_exp;
  logic [TW-1:0] w_bit_diff;
  for (genvar k = 0; k < N_OUT; k++) begin : g_chk_out
    for (genvar i = 0; i < NV; i++) begin : g_chk_vec
      assign w_bit_diff[k*NV+i] = (vec == N_IN'(i)) && (fout[k] != r_exp[k*NV+i]);
    end
  end
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      tt      <= '0;
`ifdef TT_CHECK_EN
      r_exp    <= '0;
      mismatch <= 1'b0;
      fail_idx <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (w_accept) begin
        r_state <= HOLD;
        busy    <= 1'b1;
        tt      <= '0;
`ifdef TT_CHECK_EN
        r_exp    <= exp_tt;
        mismatch <= 1'b0;
        fail_idx <= '0;
`endif
      end else if (w_sample) begin
        tt <= w_tt_next;
`ifdef TT_CHECK_EN
        if (|w_bit_diff && !mismatch) begin
          mismatch <= 1'b1;
          fail_idx <= vec;
        end
`endif
        if (w_last) begin
          r_state <= IDLE;
          busy    <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tt_scan_initiator.sv
// tb_tt_scan_initiator: two lanes (SETTLE=0 and SETTLE=2) share stimulus; each has its own
// reference model and done-triggered scoreboard.
module tb_tt_scan_initiator;
  typedef struct {
    int          dc;
    logic [15:0] tt;
    logic        mm;
    logic [2:0]  fi;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] exp_tt = 16'h0;
  int          errs = 0;
  int          chks = 0;

  always #5 clk = ~clk;

  function automatic logic [1:0] fmodel(input logic [2:0] v);
    logic a, b, c;
    {a, b, c} = v;
    return {((a | b | c) & (a ^ c)) | ~b, ((a & b) | ~c) ^ (~b | c)};
  endfunction

  function automatic logic [15:0] ref_tt();
    logic [15:0] r;
    logic [1:0]  o;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      o = fmodel(3'(i));
      r[i] = o[0];
      r[8+i] = o[1];
    end
    return r;
  endfunction

  function automatic exp_t exp_entry(input int dc, input logic [15:0] x);
    exp_t        e;
    logic [15:0] d;
    e.dc = dc;
    e.tt = ref_tt();
    d = e.tt ^ x;
    e.mm = |d;
    e.fi = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (d[i] | d[8+i]) e.fi = 3'(i);
    return e;
  endfunction

  task automatic chk(input string n, input int l, input logic [31:0] a, input logic [31:0] e);
    chks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", n, l, a, e, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int S = 2 * g;
    localparam int LEN = 8 * (S + 1);
    logic        busy, done;
    logic [2:0]  vec;
    logic [1:0]  fout;
    logic [15:0] tt;
`ifdef TT_CHECK_EN
    logic        mismatch;
    logic [2:0]  fail_idx;
`endif
    assign fout = fmodel(vec);

    tt_scan_initiator #(.N_IN(3), .N_OUT(2), .SETTLE(S)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .busy     (busy),
      .done     (done),
      .vec      (vec),
      .fout     (fout),
      .tt       (tt)
`ifdef TT_CHECK_EN
      ,
      .exp_tt   (exp_tt),
      .mismatch (mismatch),
      .fail_idx (fail_idx)
`endif
    );

    int   c = 0;
    int   e0 = 0;
    int   dcyc = -1;
    bit   active = 1'b0;
    bit   have = 1'b0;
    exp_t q[$];

    always @(negedge rst_n) begin
      active = 1'b0;
      have = 1'b0;
      dcyc = -1;
      q.delete();
    end

    always @(posedge clk) begin
      c++;
      if (!rst_n) active = 1'b0;
      else if (active) begin
        if (c == e0 + LEN) begin
          active = 1'b0;
          have = 1'b1;
          dcyc = c;
        end
      end else if (start) begin
        active = 1'b1;
        e0 = c;
        q.push_back(exp_entry(c + LEN, exp_tt));
      end
    end

    always @(negedge clk) begin
      int          ns;
      logic [7:0]  m;
      logic [15:0] et;
      exp_t        e;
      ns = active ? (c - e0) / (S + 1) : 0;
      m = 8'((1 << ns) - 1);
      et = active ? (ref_tt() & {m, m}) : (have ? ref_tt() : 16'h0);
      chk("busy", g, 32'(busy), 32'(active));
      chk("vec", g, 32'(vec), ns);
      chk("done", g, 32'(done), 32'(dcyc == c));
      chk("tt", g, 32'(tt), 32'(et));
      if (done) begin
        chk("sb_pending", g, 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          e = q.pop_front();
          chk("sb_cycle", g, c, e.dc);
          chk("sb_tt", g, 32'(tt), 32'(e.tt));
`ifdef TT_CHECK_EN
          chk("sb_mismatch", g, 32'(mismatch), 32'(e.mm));
          if (e.mm) chk("sb_fail_idx", g, 32'(fail_idx), 32'(e.fi));
`endif
        end
      end
    end
  end

  task automatic pulse();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    logic [15:0] picks [3];
    picks = '{16'h7B6E, 16'h7B6F, 16'hFB6E};
    idle(3);
    #1 rst_n = 1'b1;
    exp_tt = 16'h7B6E;
    pulse(); idle(30);
    pulse(); idle(4); pulse(); idle(30);
    @(posedge clk); #1 start = 1'b1;
    idle(75);
    #1 start = 1'b0;
    idle(30);
    pulse(); idle(3);
    #3 rst_n = 1'b0;
    idle(2);
    #1 rst_n = 1'b1;
    pulse(); idle(30);
    for (int j = 0; j < 3; j++) begin
      exp_tt = picks[(j + 1) % 3];
      pulse(); idle(30);
    end
    repeat (500) begin
      @(posedge clk); #1;
      start = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0)
        exp_tt = ($urandom_range(0, 3) == 3) ? 16'($urandom) : picks[$urandom_range(0, 2)];
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
      end
    end
    start = 1'b0;
    idle(40);
    $display("Result: errors=%0d of %0d checks", errs, chks);
    $finish;
  end
endmodule
